demux1to16_buf: RTL and testbench
=================================

DEMUX1TO16_BUF -- requirements
Module: demux1to16_buf

Interface
REQ-001 Parameter WORD_W, default 32: data width of input and every output channel.
REQ-002 Parameter CNT_W, default 8: width of the stall counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port in_data, input, WORD_W: result word to be routed.
REQ-006 Port sel, input, [0:3]: destination channel; sel[0] is MSB, channel index = {sel[0],sel[1],sel[2],sel[3]}.
REQ-007 Port in_valid, input, 1: in_data/sel valid this cycle.
REQ-008 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-009 Ports out0..out15, output, WORD_W each: registered channel data.
REQ-010 Port out_valid, output, 16: bit k set = outk holds an unconsumed word.
REQ-011 Port out_ack, input, 16: bit k = consumer of channel k takes outk this cycle.
REQ-012 Port stall_cnt, output, CNT_W: saturating count of stalled cycles.

Function
REQ-013 Each channel SHALL be a one-entry buffer: outk plus out_valid[k].
REQ-014 in_ready SHALL be combinational: (~out_valid[s] | out_ack[s]) & ~rst, s = channel selected by sel.
REQ-015 Transfer SHALL occur when in_valid & in_ready; at that edge out[s] <= in_data and out_valid[s] <= 1.
REQ-016 Write latency SHALL be 1 cycle: data visible on out[s] with out_valid[s]=1 in the cycle after transfer.
REQ-017 out_ack[k] with out_valid[k]=1 and no same-cycle transfer to k SHALL clear out_valid[k]; outk holds its value.
REQ-018 Simultaneous transfer to k and out_ack[k] SHALL leave out_valid[k]=1 with outk = new word (pass-through, no bubble).
REQ-019 out_ack[k] with out_valid[k]=0 SHALL be ignored.
REQ-020 Acks on any set of channels SHALL be processed in the same cycle, independent of the selected channel.
REQ-021 Non-selected channels SHALL never change data on a transfer.
REQ-022 When in_valid=1 and in_ready=0, in_data/sel are not consumed; the producer holds them.
REQ-023 stall_cnt SHALL increment by 1 each cycle in_valid & ~in_ready, saturating at 2^CNT_W-1; no wrap.
REQ-024 in_ready SHALL depend only on the selected channel; a full channel blocks only writes addressed to it.
REQ-025 sel SHALL be sampled only when in_valid=1; sel changes while in_valid=0 have no effect.

Reset
REQ-026 While rst=1: out0..out15 = 0, out_valid = 0, stall_cnt = 0, in_ready = 0, asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words; no transfer completes in a cycle where rst is high.
REQ-028 First transfer SHALL be possible in the first clock edge after rst deasserts.

Structure
REQ-029 Shared package alu_pkg SHALL hold WORD_W, SEL_W=4, NCH=16 and the sel-to-index decode function.
REQ-030 One sub-module demux_slot (one-entry buffer: data reg, valid flag, write enable, ack) SHALL be instantiated 16 times.
REQ-031 Top level SHALL contain only sel decode, in_ready mux, and the stall counter.

Verification
REQ-032 Reset, then in_valid=1, sel=4'b0101, in_data=32'hDEADBEEF -> next cycle out5=32'hDEADBEEF, out_valid=16'h0020, all other outs 0.
REQ-033 Channel 3 full, no ack, in_valid=1 with sel=3 for 10 cycles -> in_ready=0, out3 unchanged, stall_cnt=10.
REQ-034 Channel 3 full, out_ack[3]=1 with transfer sel=3, in_data=32'h12345678 -> out_valid[3] stays 1, out3=32'h12345678.
REQ-035 Channel 3 full, transfer to sel=4'b1111 data 32'h1 -> accepted, out15=1, out3 unchanged; out_ack=16'h8008 next -> out_valid=0.
REQ-036 Stall held 300 cycles -> stall_cnt saturates at 255; rst pulse mid-stall (not aligned to clk) -> immediately all outputs 0, in_ready=0.
REQ-037 out_ack=16'hFFFF with out_valid=0 -> no state change; random 10k-cycle stream against scoreboard -> every word delivered once, in order per channel.

Source files
------------

// File: rtl/demux1to16_buf_pkg.sv
// Shared constants and the sel-to-channel decode for the 1-to-16 buffered demux.
package alu_pkg;

    localparam int WORD_W = 32;  // default data width of input and every channel
    localparam int SEL_W  = 4;   // width of the destination select
    localparam int NCH    = 16;  // number of output channels

    // sel is declared [0:SEL_W-1] with sel[0] as the MSB; this returns the
    // conventional little-endian channel index.
    function automatic logic [SEL_W-1:0] sel_to_idx(input logic [0:SEL_W-1] sel);
        logic [SEL_W-1:0] idx;
        for (int i = 0; i < SEL_W; i++) begin
            idx[SEL_W-1-i] = sel[i];
        end
        return idx;
    endfunction

endpackage

// File: rtl/demux1to16_buf_if.sv
// Producer/consumer bus of the 1-to-16 buffered demux.
//
// Handshake: a word moves from the producer into channel s (s = sel decoded,
// sel[0] MSB) on a rising edge where in_valid && in_ready. While in_valid is
// high and in_ready is low the producer holds in_data/sel unchanged. A channel
// word is offered while out_valid[k] is high and is taken on an edge where
// out_ack[k] is high; out_ack[k] while out_valid[k] is low means nothing.
interface demux1to16_buf_if #(
    parameter int WORD_W = alu_pkg::WORD_W
);
    import alu_pkg::*;

    logic [WORD_W-1:0] in_data;
    logic [0:SEL_W-1]  sel;
    logic              in_valid;
    logic              in_ready;

    logic [WORD_W-1:0] out0,  out1,  out2,  out3;
    logic [WORD_W-1:0] out4,  out5,  out6,  out7;
    logic [WORD_W-1:0] out8,  out9,  out10, out11;
    logic [WORD_W-1:0] out12, out13, out14, out15;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ack;

    // Environment side: drives the producer inputs and the consumer acks.
    modport master (
        output in_data, sel, in_valid, out_ack,
        input  in_ready, out_valid,
        input  out0, out1, out2, out3, out4, out5, out6, out7,
        input  out8, out9, out10, out11, out12, out13, out14, out15
    );

    // Demux side.
    modport slave (
        input  in_data, sel, in_valid, out_ack,
        output in_ready, out_valid,
        output out0, out1, out2, out3, out4, out5, out6, out7,
        output out8, out9, out10, out11, out12, out13, out14, out15
    );

endinterface

// File: rtl/demux1to16_buf_slot.sv
// One-entry channel buffer: a data register plus a valid flag.
module demux_slot #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              ack_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o
);

    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    // A write wins over an ack so a same-cycle ack+write passes straight
    // through with no bubble; an ack alone only drops valid, data is kept.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (wr_en_i) begin
            data_d  = wr_data_i;
            valid_d = 1'b1;
        end else if (ack_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer state register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux1to16_buf.sv
// 1-to-16 demultiplexer with a one-entry buffer per channel and a saturating
// count of cycles where the producer was held off.
module demux1to16_buf
    import alu_pkg::*;
#(
    parameter int WORD_W = alu_pkg::WORD_W,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    demux1to16_buf_if.slave      bus,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic [SEL_W-1:0]  sel_idx;
    logic [NCH-1:0]    wr_en;
    logic [NCH-1:0]    slot_valid;
    logic [WORD_W-1:0] slot_data [NCH];
    logic              xfer;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign sel_idx = sel_to_idx(bus.sel);

    // Only the addressed channel gates the producer; an ack on that channel
    // frees its slot in the same cycle. Held low throughout reset.
    assign bus.in_ready = (~slot_valid[sel_idx] | bus.out_ack[sel_idx]) & ~rst;
    assign xfer         = bus.in_valid & bus.in_ready;
    assign stall        = bus.in_valid & ~bus.in_ready;

    // One-hot write enable towards the addressed channel.
    always_comb begin
        wr_en          = '0;
        wr_en[sel_idx] = xfer;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .WORD_W (WORD_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en[k]),
            .wr_data_i (bus.in_data),
            .ack_i     (bus.out_ack[k]),
            .data_o    (slot_data[k]),
            .valid_o   (slot_valid[k])
        );
    end

    assign bus.out_valid = slot_valid;
    assign bus.out0  = slot_data[0];
    assign bus.out1  = slot_data[1];
    assign bus.out2  = slot_data[2];
    assign bus.out3  = slot_data[3];
    assign bus.out4  = slot_data[4];
    assign bus.out5  = slot_data[5];
    assign bus.out6  = slot_data[6];
    assign bus.out7  = slot_data[7];
    assign bus.out8  = slot_data[8];
    assign bus.out9  = slot_data[9];
    assign bus.out10 = slot_data[10];
    assign bus.out11 = slot_data[11];
    assign bus.out12 = slot_data[12];
    assign bus.out13 = slot_data[13];
    assign bus.out14 = slot_data[14];
    assign bus.out15 = slot_data[15];

    // Stall counter next value: count up on a held-off cycle, stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_demux1to16_buf.sv
// Bench for demux1to16_buf: directed scenarios plus a random stream checked
// against a per-channel behavioural model and an in-order scoreboard.
module tb_demux1to16_buf;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int CW  = 8;
    localparam int SAT = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] stall_cnt;

    demux1to16_buf_if #(.WORD_W(W)) bus();

    demux1to16_buf #(
        .WORD_W (W),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: what each channel holds and whether it is unconsumed.
    logic [15:0]  m_valid;
    logic [W-1:0] m_data [16];
    int           m_stall;
    logic         exp_ready;
    logic         obs_ready;

    typedef struct packed {
        logic [3:0]   ch;
        logic [W-1:0] data;
    } sb_t;
    sb_t exp_q[$];

    function automatic logic [W-1:0] get_out(input int k);
        case (k)
            0:  return bus.out0;
            1:  return bus.out1;
            2:  return bus.out2;
            3:  return bus.out3;
            4:  return bus.out4;
            5:  return bus.out5;
            6:  return bus.out6;
            7:  return bus.out7;
            8:  return bus.out8;
            9:  return bus.out9;
            10: return bus.out10;
            11: return bus.out11;
            12: return bus.out12;
            13: return bus.out13;
            14: return bus.out14;
            default: return bus.out15;
        endcase
    endfunction

    task automatic set_idle();
        bus.in_valid = 1'b0;
        bus.sel      = '0;
        bus.in_data  = '0;
        bus.out_ack  = '0;
    endtask

    task automatic model_clear();
        m_valid = '0;
        m_stall = 0;
        for (int k = 0; k < 16; k++) m_data[k] = '0;
        exp_q.delete();
    endtask

    // Leaves time at posedge+1 with rst low.
    task automatic apply_reset();
        rst = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock of stimulus; samples in_ready before the edge and advances the model.
    task automatic drive_cycle(input logic v, input logic [3:0] s,
                               input logic [W-1:0] d, input logic [15:0] ack);
        logic ready;
        bus.in_valid = v;
        bus.sel      = s;
        bus.in_data  = d;
        bus.out_ack  = ack;
        ready        = !m_valid[s] || ack[s];
        exp_ready    = ready;
        #3;
        obs_ready = bus.in_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            if (v && ready && (k == int'(s))) begin
                m_valid[k] = 1'b1;
                m_data[k]  = d;
            end else if (ack[k]) begin
                m_valid[k] = 1'b0;
            end
        end
        if (v && !ready && (m_stall < SAT)) m_stall++;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        set_idle();
        bus.in_valid = 1'b1;
        bus.sel      = 4'd5;
        bus.in_data  = 32'h55AA55AA;
        #2;
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        tests_run++;
        if (bus.out_valid !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %h expected 0000", bus.out_valid);
        end
        tests_run++;
        if (stall_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
        @(posedge clk);
        #1;
        bad = 0;
        for (int k = 0; k < 16; k++) if (get_out(k) !== '0) bad++;
        tests_run++;
        if ((bad != 0) || (bus.out_valid !== 16'h0000)) begin
            tests_failed++;
            $display("FAIL reset_no_transfer: %0d nonzero outs, out_valid %h expected 0 and 0000",
                     bad, bus.out_valid);
        end
        set_idle();
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_single_write();
        int bad;
        apply_reset();
        drive_cycle(1'b1, 4'b0101, 32'hDEADBEEF, 16'h0000);
        tests_run++;
        if (obs_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_ready: got %b expected 1", obs_ready);
        end
        tests_run++;
        if (bus.out5 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL single_out5: got %h expected deadbeef", bus.out5);
        end
        tests_run++;
        if (bus.out_valid !== 16'h0020) begin
            tests_failed++;
            $display("FAIL single_out_valid: got %h expected 0020", bus.out_valid);
        end
        bad = 0;
        for (int k = 0; k < 16; k++) if ((k != 5) && (get_out(k) !== '0)) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL single_other_outs: got %0d nonzero channels expected 0", bad);
        end
        set_idle();
    endtask

    task automatic test_stall();
        int ready_seen;
        apply_reset();
        drive_cycle(1'b1, 4'd3, 32'hA5A50003, 16'h0000);
        ready_seen = 0;
        repeat (10) begin
            drive_cycle(1'b1, 4'd3, $urandom(), 16'h0000);
            if (obs_ready !== 1'b0) ready_seen++;
        end
        tests_run++;
        if (ready_seen != 0) begin
            tests_failed++;
            $display("FAIL stall_ready: in_ready high %0d times expected 0", ready_seen);
        end
        tests_run++;
        if (bus.out3 !== 32'hA5A50003) begin
            tests_failed++;
            $display("FAIL stall_out3: got %h expected a5a50003", bus.out3);
        end
        tests_run++;
        if (stall_cnt !== 8'd10) begin
            tests_failed++;
            $display("FAIL stall_cnt10: got %0d expected 10", stall_cnt);
        end
        set_idle();
    endtask

    task automatic test_passthrough();
        apply_reset();
        drive_cycle(1'b1, 4'd3, 32'hCAFE0003, 16'h0000);
        drive_cycle(1'b1, 4'd3, 32'h12345678, 16'h0008);
        tests_run++;
        if (obs_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL pass_ready: got %b expected 1", obs_ready);
        end
        tests_run++;
        if (bus.out_valid[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pass_valid3: got %b expected 1", bus.out_valid[3]);
        end
        tests_run++;
        if (bus.out3 !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL pass_out3: got %h expected 12345678", bus.out3);
        end
        set_idle();
    endtask

    task automatic test_other_channel();
        apply_reset();
        drive_cycle(1'b1, 4'd3, 32'h33333333, 16'h0000);
        drive_cycle(1'b1, 4'b1111, 32'h00000001, 16'h0000);
        tests_run++;
        if (obs_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL other_ready: got %b expected 1", obs_ready);
        end
        tests_run++;
        if ((bus.out15 !== 32'h1) || (bus.out3 !== 32'h33333333)) begin
            tests_failed++;
            $display("FAIL other_data: out15 %h out3 %h expected 00000001 33333333",
                     bus.out15, bus.out3);
        end
        tests_run++;
        if (bus.out_valid !== 16'h8008) begin
            tests_failed++;
            $display("FAIL other_valid: got %h expected 8008", bus.out_valid);
        end
        drive_cycle(1'b0, 4'd0, 32'h0, 16'h8008);
        tests_run++;
        if (bus.out_valid !== 16'h0000) begin
            tests_failed++;
            $display("FAIL other_ack_valid: got %h expected 0000", bus.out_valid);
        end
        tests_run++;
        if ((bus.out15 !== 32'h1) || (bus.out3 !== 32'h33333333)) begin
            tests_failed++;
            $display("FAIL other_ack_hold: out15 %h out3 %h expected 00000001 33333333",
                     bus.out15, bus.out3);
        end
        set_idle();
    endtask

    task automatic test_ack_empty();
        int bad;
        apply_reset();
        drive_cycle(1'b0, 4'($urandom_range(0, 15)), $urandom(), 16'hFFFF);
        bad = 0;
        for (int k = 0; k < 16; k++) if (get_out(k) !== '0) bad++;
        tests_run++;
        if ((bus.out_valid !== 16'h0000) || (bad != 0)) begin
            tests_failed++;
            $display("FAIL ack_empty: out_valid %h nonzero outs %0d expected 0000 and 0",
                     bus.out_valid, bad);
        end
        drive_cycle(1'b1, 4'd7, 32'h77777777, 16'h0000);
        drive_cycle(1'b0, 4'd7, 32'h0, 16'hFF7F);
        tests_run++;
        if ((bus.out_valid !== 16'h0080) || (bus.out7 !== 32'h77777777)) begin
            tests_failed++;
            $display("FAIL ack_others: out_valid %h out7 %h expected 0080 77777777",
                     bus.out_valid, bus.out7);
        end
        set_idle();
    endtask

    task automatic test_saturate_and_reset();
        int bad;
        apply_reset();
        drive_cycle(1'b1, 4'd3, 32'h0BADF00D, 16'h0000);
        repeat (300) drive_cycle(1'b1, 4'd3, $urandom(), 16'h0000);
        tests_run++;
        if (stall_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_cnt: got %0d expected 255", stall_cnt);
        end
        drive_cycle(1'b1, 4'd9, 32'h99999999, 16'h0000);
        // Pulse reset between clock edges while the stall is still pending.
        bus.sel = 4'd3;
        #2;
        rst = 1'b1;
        #1;
        bad = 0;
        for (int k = 0; k < 16; k++) if (get_out(k) !== '0) bad++;
        tests_run++;
        if ((bus.out_valid !== 16'h0000) || (bad != 0) || (stall_cnt !== 8'd0)) begin
            tests_failed++;
            $display("FAIL async_reset_state: out_valid %h nonzero outs %0d stall %0d expected 0000 0 0",
                     bus.out_valid, bad, stall_cnt);
        end
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_ready: got %b expected 0", bus.in_ready);
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        model_clear();
        #1;
        drive_cycle(1'b1, 4'd9, 32'h90909090, 16'h0000);
        tests_run++;
        if ((bus.out_valid !== 16'h0200) || (bus.out9 !== 32'h90909090)) begin
            tests_failed++;
            $display("FAIL first_after_reset: out_valid %h out9 %h expected 0200 90909090",
                     bus.out_valid, bus.out9);
        end
        set_idle();
    endtask

    task automatic test_random();
        logic         v;
        logic [3:0]   s;
        logic [W-1:0] d;
        logic [15:0]  ack;
        int           found;
        int           bad_ch;
        apply_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            v   = ($urandom_range(0, 3) != 0);
            s   = 4'($urandom_range(0, 15));
            d   = $urandom();
            ack = 16'($urandom()) & 16'($urandom());
            // Consumer side: each acked full channel must present the oldest
            // outstanding word written to it.
            for (int k = 0; k < 16; k++) begin
                if (ack[k] && m_valid[k]) begin
                    found = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (int'(exp_q[i].ch) == k) begin
                            found = i;
                            break;
                        end
                    end
                    tests_run++;
                    if (found < 0) begin
                        tests_failed++;
                        $display("FAIL rand_sb_empty cycle %0d ch %0d: got %h expected no word",
                                 cyc, k, get_out(k));
                    end else begin
                        if (get_out(k) !== exp_q[found].data) begin
                            tests_failed++;
                            $display("FAIL rand_sb_data cycle %0d ch %0d: got %h expected %h",
                                     cyc, k, get_out(k), exp_q[found].data);
                        end
                        exp_q.delete(found);
                    end
                end
            end
            drive_cycle(v, s, d, ack);
            if (v && exp_ready) exp_q.push_back({s, d});
            tests_run++;
            if (obs_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL rand_ready cycle %0d: got %b expected %b", cyc, obs_ready, exp_ready);
            end
            tests_run++;
            if (bus.out_valid !== m_valid) begin
                tests_failed++;
                $display("FAIL rand_valid cycle %0d: got %h expected %h", cyc, bus.out_valid, m_valid);
            end
            tests_run++;
            if (stall_cnt !== CW'(m_stall)) begin
                tests_failed++;
                $display("FAIL rand_stall cycle %0d: got %0d expected %0d", cyc, stall_cnt, m_stall);
            end
            bad_ch = -1;
            for (int k = 0; k < 16; k++) if ((bad_ch < 0) && (get_out(k) !== m_data[k])) bad_ch = k;
            tests_run++;
            if (bad_ch >= 0) begin
                tests_failed++;
                $display("FAIL rand_data cycle %0d ch %0d: got %h expected %h",
                         cyc, bad_ch, get_out(bad_ch), m_data[bad_ch]);
            end
        end
        // Words still buffered must be exactly the ones never consumed.
        tests_run++;
        if (exp_q.size() != $countones(bus.out_valid)) begin
            tests_failed++;
            $display("FAIL rand_leftover_count: got %0d valid channels expected %0d",
                     $countones(bus.out_valid), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if ((bus.out_valid[exp_q[i].ch] !== 1'b1) || (get_out(int'(exp_q[i].ch)) !== exp_q[i].data)) begin
                tests_failed++;
                $display("FAIL rand_leftover ch %0d: got valid %b data %h expected 1 %h",
                         exp_q[i].ch, bus.out_valid[exp_q[i].ch], get_out(int'(exp_q[i].ch)),
                         exp_q[i].data);
            end
        end
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        model_clear();
        test_reset();
        test_single_write();
        test_stall();
        test_passthrough();
        test_other_channel();
        test_ack_empty();
        test_saturate_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete within time limit");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "timeout");
    end

endmodule
